// File: rtl/sum3_acc_pkg.sv
// sum3_acc_pkg: shared types and constants for the sum3 accumulator.
// Holds the frame FSM state encoding and the width of the adder-stage sum.
// Imported by sum3_acc_datapath and sum3_accumulator.
package sum3_acc_pkg;

  // Width of the unsigned sum produced by the three-operand 4-bit adder
  localparam int SUM_W = 6;

  // Frame FSM: collecting beats, or holding a finished frame for the consumer
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/sum3_acc_datapath.sv
// sum3_acc_datapath: next-accumulator computation for one input beat.
// Combinational, zero latency; no flow control of its own (enable from the top).
// Build option SUM3_ACC_SAT_EN: defined -> saturating add, undefined -> wrapping add.
module sum3_acc_datapath
  import sum3_acc_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [SUM_W-1:0] i_sum,
  input  logic             i_en,
  output logic [ACC_W-1:0] o_acc_nxt,
  output logic             o_sat
);

`ifdef SUM3_ACC_SAT_EN
  // One extra bit keeps the carry so a saturating add can be detected
  logic [ACC_W:0] w_total;

  assign w_total = {1'b0, i_acc} + (ACC_W+1)'(i_sum);

  // Clamp at all-ones on carry-out and flag it; hold the accumulator when idle
  always_comb begin
    o_acc_nxt = i_acc;
    o_sat     = 1'b0;
    if (i_en) begin
      if (w_total[ACC_W]) begin
        o_acc_nxt = '1;
        o_sat     = 1'b1;
      end else begin
        o_acc_nxt = w_total[ACC_W-1:0];
      end
    end
  end
`else
  // Modulo-2^ACC_W add: the carry is simply dropped
  logic [ACC_W-1:0] w_total;

  assign w_total = i_acc + ACC_W'(i_sum);

  // Take the wrapped sum when a beat is accepted; saturation never occurs
  always_comb begin
    o_acc_nxt = i_acc;
    o_sat     = 1'b0;
    if (i_en) begin
      o_acc_nxt = w_total;
    end
  end
`endif

endmodule

// File: rtl/sum3_accumulator.sv
// sum3_accumulator: sums COUNT adder results (or fewer on flush) into one frame total.
// Latency: out_valid rises the cycle after the closing beat or flush.
// Backpressure: in_ready drops while a frame waits for out_ready. Build option: SUM3_ACC_SAT_EN.
module sum3_accumulator
  import sum3_acc_pkg::*;
#(
  parameter  int COUNT = 8,
  parameter  int ACC_W = 12,
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic             w_accept;
  logic             w_hs;
  logic             w_close;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sat_hit;

  // in_ready/out_valid come from registered state only, so these are
  // free of any combinational path from in_valid or out_ready.
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_cnt_nxt = w_accept ? (r_cnt + CNT_W'(1)) : r_cnt;

  // A frame closes when it fills, or on flush once it holds at least one beat
  // (a beat arriving together with flush is counted in the frame).
  assign w_close = (w_accept && (w_cnt_nxt == CNT_W'(COUNT))) ||
                   (flush && (w_cnt_nxt != '0));

  sum3_acc_datapath #(
    .ACC_W (ACC_W)
  ) u_datapath (
    .i_acc     (r_acc),
    .i_sum     (in_sum),
    .i_en      (w_accept),
    .o_acc_nxt (w_acc_nxt),
    .o_sat     (w_sat_hit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: close a frame into DONE, release it on output handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_close)   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // FSM outputs: accept input only while collecting, present result only when done
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Frame accumulator, beat counter and sticky saturation flag; all clear on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_hs) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_sat <= r_sat | w_sat_hit;
    end
  end

  // Accumulator state is frozen in DONE, so it doubles as the output holding register
  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_sum3_accumulator.sv
// tb_sum3_accumulator: directed checks of two accumulator instances.
// Instance A: COUNT=4, ACC_W=12. Instance B: COUNT=8, ACC_W=8.
// Expected overflow values follow the SUM3_ACC_SAT_EN build option.
module tb_sum3_accumulator;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_sat;
  logic [5:0]  a_in_sum;
  logic [11:0] a_out_acc;
  logic [2:0]  a_out_count;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_sat;
  logic [5:0]  b_in_sum;
  logic [7:0]  b_out_acc;
  logic [3:0]  b_out_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SUM3_ACC_SAT_EN
  localparam int EXP5_ACC = 255;
  localparam int EXP5_SAT = 1;
  localparam int EXP8_ACC = 255;
  localparam int EXP8_SAT = 1;
`else
  localparam int EXP5_ACC = 59;
  localparam int EXP5_SAT = 0;
  localparam int EXP8_ACC = 248;
  localparam int EXP8_SAT = 0;
`endif

  sum3_accumulator #(.COUNT(4), .ACC_W(12)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_sum    (a_in_sum),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_acc   (a_out_acc),
    .out_count (a_out_count),
    .out_sat   (a_out_sat)
  );

  sum3_accumulator #(.COUNT(8), .ACC_W(8)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_sum    (b_in_sum),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_acc   (b_out_acc),
    .out_count (b_out_count),
    .out_sat   (b_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_sum = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid  = 1'b0; b_in_sum = '0; b_flush = 1'b0; b_out_ready = 1'b1;

    // ---- reset state ----
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_acc",   a_out_acc,   0);
    chk("rst_out_count", a_out_count, 0);
    chk("rst_out_sat",   a_out_sat,   0);
    chk("rst_b_valid",   b_out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_in_ready",  a_in_ready,  1);
    cyc();

    // ---- full frame, A: 10,20,30,40 back-to-back, out_ready=1 ----
    a_in_valid = 1'b1;
    a_in_sum = 6'd10; cyc();
    a_in_sum = 6'd20; cyc();
    a_in_sum = 6'd30; cyc();
    chk("full_no_early_valid", a_out_valid, 0);
    chk("full_in_ready_mid",   a_in_ready,  1);
    a_in_sum = 6'd40; cyc();
    a_in_valid = 1'b0;
    chk("full_out_valid", a_out_valid, 1);
    chk("full_out_acc",   a_out_acc,   100);
    chk("full_out_count", a_out_count, 4);
    chk("full_in_ready0", a_in_ready,  0);
    cyc();
    chk("full_hs_valid0", a_out_valid, 0);
    chk("full_in_ready1", a_in_ready,  1);

    // ---- backpressure, A: frame 1,2,3,4 with out_ready low ----
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sum = 6'd1; cyc();
    a_in_sum = 6'd2; cyc();
    a_in_sum = 6'd3; cyc();
    a_in_sum = 6'd4; cyc();
    a_in_sum = 6'd50;  // offered while DONE: must be ignored
    chk("bp_valid_first", a_out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid_held", a_out_valid, 1);
      chk("bp_acc_stable", a_out_acc,   10);
      chk("bp_cnt_stable", a_out_count, 4);
      chk("bp_in_ready0",  a_in_ready,  0);
    end
    a_out_ready = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    chk("bp_hs_valid0",  a_out_valid, 0);
    chk("bp_in_ready1",  a_in_ready,  1);
    // next frame proves nothing offered during DONE or handshake leaked in
    a_in_valid = 1'b1;
    a_in_sum   = 6'd2;
    repeat (4) cyc();
    a_in_valid = 1'b0;
    chk("bp_next_valid", a_out_valid, 1);
    chk("bp_next_acc",   a_out_acc,   8);
    chk("bp_next_count", a_out_count, 4);
    cyc();

    // ---- early flush, B: 63 then 1 with flush on the second beat ----
    b_in_valid = 1'b1;
    b_in_sum = 6'd63; cyc();
    b_in_sum = 6'd1; b_flush = 1'b1; cyc();
    b_in_valid = 1'b0; b_flush = 1'b0;
    chk("flush_valid", b_out_valid, 1);
    chk("flush_acc",   b_out_acc,   64);
    chk("flush_count", b_out_count, 2);
    chk("flush_sat",   b_out_sat,   0);
    cyc();
    chk("flush_hs_valid0", b_out_valid, 0);
    // flush with an empty frame is ignored
    b_flush = 1'b1; cyc();
    b_flush = 1'b0;
    chk("flush_empty_valid0", b_out_valid, 0);
    chk("flush_empty_ready",  b_in_ready,  1);
    cyc();
    chk("flush_empty_valid0b", b_out_valid, 0);
    // flush alone after a single beat closes a one-beat frame
    b_in_valid = 1'b1; b_in_sum = 6'd7; cyc();
    b_in_valid = 1'b0; b_flush = 1'b1; cyc();
    b_flush = 1'b0;
    chk("flush1_valid", b_out_valid, 1);
    chk("flush1_acc",   b_out_acc,   7);
    chk("flush1_count", b_out_count, 1);
    cyc();

    // ---- overflow, B: eight beats of 63 into an 8-bit accumulator ----
    b_in_valid = 1'b1;
    b_in_sum   = 6'd63;
    repeat (4) cyc();
    chk("ovf4_acc",   b_out_acc,   252);
    chk("ovf4_sat",   b_out_sat,   0);
    chk("ovf4_valid", b_out_valid, 0);
    cyc();
    chk("ovf5_acc", b_out_acc, EXP5_ACC);
    chk("ovf5_sat", b_out_sat, EXP5_SAT);
    repeat (3) cyc();
    b_in_valid = 1'b0;
    chk("ovf_valid", b_out_valid, 1);
    chk("ovf_count", b_out_count, 8);
    chk("ovf_acc",   b_out_acc,   EXP8_ACC);
    chk("ovf_sat",   b_out_sat,   EXP8_SAT);
    cyc();
    chk("ovf_hs_valid0", b_out_valid, 0);
    chk("ovf_hs_sat0",   b_out_sat,   0);

    // ---- reset mid-frame, A: two beats of 5 then async reset ----
    a_in_valid = 1'b1;
    a_in_sum   = 6'd5;
    repeat (2) cyc();
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_acc",   a_out_acc,   0);
    chk("mrst_count", a_out_count, 0);
    chk("mrst_sat",   a_out_sat,   0);
    cyc();
    rst_n = 1'b1;
    chk("mrst_ready", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_sum   = 6'd1;
    repeat (4) cyc();
    a_in_valid = 1'b0;
    chk("mrst_next_valid", a_out_valid, 1);
    chk("mrst_next_acc",   a_out_acc,   4);
    chk("mrst_next_count", a_out_count, 4);
    cyc();
    chk("mrst_next_hs", a_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
